// File: rtl/jtgng_rom_arb.sv
// jtgng_rom_arb
//
// Four-slot ROM read arbiter sitting in front of an SDRAM controller.
// Each slot owns a one-word cache entry (address, data, valid). A slot whose
// request hits its entry is answered combinationally. Misses are served one at
// a time by a round-robin grant and a single outstanding SDRAM read.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   downloading         : ROM download in progress; fetches aborted, caches flushed
//   slotN_cs/addr       : slot N request (level) and word address, N = 0..3
//   slotN_ok/dout       : slot N data valid for current address, cached data
//   sdram_req/addr      : read request and address to the SDRAM controller
//   sdram_ack           : controller accepted the request (pulse)
//   data_rdy/data_read  : read data strobe and data from the controller
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no fetch outstanding; grant the next pending slot, if any
// WAIT_ACK | sdram_req held with the latched address until the controller acks
// WAIT_RDY | request accepted; waiting for read data to fill the granted slot

module jtgng_rom_arb #(
   parameter int AW = 22,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          downloading,

   input  logic          slot0_cs,
   input  logic          slot1_cs,
   input  logic          slot2_cs,
   input  logic          slot3_cs,
   input  logic [AW-1:0] slot0_addr,
   input  logic [AW-1:0] slot1_addr,
   input  logic [AW-1:0] slot2_addr,
   input  logic [AW-1:0] slot3_addr,
   output logic          slot0_ok,
   output logic          slot1_ok,
   output logic          slot2_ok,
   output logic          slot3_ok,
   output logic [DW-1:0] slot0_dout,
   output logic [DW-1:0] slot1_dout,
   output logic [DW-1:0] slot2_dout,
   output logic [DW-1:0] slot3_dout,

   output logic          sdram_req,
   output logic [AW-1:0] sdram_addr,
   input  logic          sdram_ack,
   input  logic          data_rdy,
   input  logic [DW-1:0] data_read
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      WAIT_RDY = 2'd2
   } state_t;

   state_t        state, state_nxt;

   logic [AW-1:0] cache_addr [4];
   logic [DW-1:0] cache_data [4];
   logic [3:0]    valid;

   logic [1:0]    last_grant, last_grant_nxt;
   logic [1:0]    grant, grant_nxt;
   logic          sdram_req_nxt;
   logic [AW-1:0] sdram_addr_nxt;
   logic          capture;

   logic [3:0]    cs;
   logic [AW-1:0] addr [4];
   logic [3:0]    ok;
   logic [3:0]    pending;
   logic          found;
   logic [1:0]    pick;

   assign cs      = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
   assign addr[0] = slot0_addr;
   assign addr[1] = slot1_addr;
   assign addr[2] = slot2_addr;
   assign addr[3] = slot3_addr;

   // Hit detection uses the full address; no partial matching.
   always_comb begin
      ok = '0;
      for (int i = 0; i < 4; i++) begin
         ok[i] = cs[i] & valid[i] & (addr[i] == cache_addr[i]);
      end
   end

   assign pending = cs & ~ok;

   assign slot0_ok   = ok[0];
   assign slot1_ok   = ok[1];
   assign slot2_ok   = ok[2];
   assign slot3_ok   = ok[3];
   assign slot0_dout = cache_data[0];
   assign slot1_dout = cache_data[1];
   assign slot2_dout = cache_data[2];
   assign slot3_dout = cache_data[3];

   // Round-robin search starting one past the last grant; k = 4 wraps back to
   // the last granted slot so it is considered only after the other three.
   always_comb begin
      found = 1'b0;
      pick  = last_grant + 2'd1;
      for (int k = 1; k <= 4; k++) begin
         if (!found && pending[last_grant + 2'(k)]) begin
            found = 1'b1;
            pick  = last_grant + 2'(k);
         end
      end
   end

   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      last_grant_nxt = last_grant;
      sdram_req_nxt  = sdram_req;
      sdram_addr_nxt = sdram_addr;
      capture        = 1'b0;

      case (state)
         IDLE: begin
            if (found) begin
               grant_nxt      = pick;
               last_grant_nxt = pick;
               sdram_addr_nxt = addr[pick];
               sdram_req_nxt  = 1'b1;
               state_nxt      = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (sdram_ack) begin
               sdram_req_nxt = 1'b0;
               if (data_rdy) begin
                  capture   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = WAIT_RDY;
               end
            end
         end
         WAIT_RDY: begin
            if (data_rdy) begin
               capture   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt     = IDLE;
            sdram_req_nxt = 1'b0;
         end
      endcase

      // Download overrides everything: abort without capture, no new grants.
      if (downloading) begin
         state_nxt      = IDLE;
         sdram_req_nxt  = 1'b0;
         capture        = 1'b0;
         grant_nxt      = grant;
         last_grant_nxt = last_grant;
         sdram_addr_nxt = sdram_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= 2'd0;
         last_grant <= 2'd3;
         sdram_req  <= 1'b0;
         sdram_addr <= '0;
         valid      <= '0;
         for (int i = 0; i < 4; i++) begin
            cache_addr[i] <= '0;
            cache_data[i] <= '0;
         end
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         last_grant <= last_grant_nxt;
         sdram_req  <= sdram_req_nxt;
         sdram_addr <= sdram_addr_nxt;
         if (downloading) begin
            valid <= '0;
         end else if (capture) begin
            // sdram_addr still holds the address latched at grant time, so a
            // slot that moved on mid-fetch gets the data under the old address.
            valid[grant]      <= 1'b1;
            cache_addr[grant] <= sdram_addr;
            cache_data[grant] <= data_read;
         end
      end
   end

endmodule

// File: tb/tb_jtgng_rom_arb.sv
module tb_jtgng_rom_arb;

   localparam int AW = 22;
   localparam int DW = 32;

   typedef struct {
      int          slot;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          downloading;
   logic [3:0]    cs;
   logic [AW-1:0] addr [4];
   logic [3:0]    ok;
   logic [DW-1:0] dout [4];
   logic          sdram_req;
   logic [AW-1:0] sdram_addr;
   logic          sdram_ack;
   logic          data_rdy;
   logic [DW-1:0] data_read;

   exp_t sb[$];
   int   n_cmp;
   int   n_err;

   jtgng_rom_arb #(.AW(AW), .DW(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .downloading (downloading),
      .slot0_cs    (cs[0]),
      .slot1_cs    (cs[1]),
      .slot2_cs    (cs[2]),
      .slot3_cs    (cs[3]),
      .slot0_addr  (addr[0]),
      .slot1_addr  (addr[1]),
      .slot2_addr  (addr[2]),
      .slot3_addr  (addr[3]),
      .slot0_ok    (ok[0]),
      .slot1_ok    (ok[1]),
      .slot2_ok    (ok[2]),
      .slot3_ok    (ok[3]),
      .slot0_dout  (dout[0]),
      .slot1_dout  (dout[1]),
      .slot2_dout  (dout[2]),
      .slot3_dout  (dout[3]),
      .sdram_req   (sdram_req),
      .sdram_addr  (sdram_addr),
      .sdram_ack   (sdram_ack),
      .data_rdy    (data_rdy),
      .data_read   (data_read)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: observed still running, expected finished");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic push(input int slot, input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      e.slot = slot;
      e.addr = a;
      e.data = d;
      sb.push_back(e);
   endtask

   // Waits (bounded) for a request, pops the expected grant and checks its address.
   task automatic wait_grant(output exp_t e, output bit got);
      int n;
      n   = 0;
      got = 1'b0;
      e.slot = 0;
      e.addr = '0;
      e.data = '0;
      while (!sdram_req && n < 20) begin
         step();
         #1;
         n++;
      end
      chk("grant_seen", {63'd0, sdram_req}, 64'd1);
      if (!sdram_req) return;
      n_cmp++;
      assert (sb.size() != 0) else begin
         n_err++;
         $error("FAIL sb_empty: observed request to %0h expected none", sdram_addr);
         return;
      end
      e = sb.pop_front();
      chk("sdram_addr", 64'(sdram_addr), 64'(e.addr));
      got = 1'b1;
   endtask

   task automatic fetch(input bit combined);
      exp_t e;
      bit   got;
      wait_grant(e, got);
      if (!got) return;
      sdram_ack = 1'b1;
      if (combined) begin
         data_rdy  = 1'b1;
         data_read = e.data;
      end
      step();
      sdram_ack = 1'b0;
      data_rdy  = 1'b0;
      #1;
      chk("req_clear", {63'd0, sdram_req}, 64'd0);
      if (!combined) begin
         step();
         data_rdy  = 1'b1;
         data_read = e.data;
         step();
         data_rdy  = 1'b0;
         #1;
      end
      chk($sformatf("dout%0d", e.slot), 64'(dout[e.slot]), 64'(e.data));
   endtask

   initial begin
      exp_t e;
      bit   got;
      n_cmp       = 0;
      n_err       = 0;
      rst         = 1'b1;
      downloading = 1'b0;
      cs          = 4'h0;
      for (int i = 0; i < 4; i++) addr[i] = '0;
      sdram_ack   = 1'b0;
      data_rdy    = 1'b0;
      data_read   = '0;
      step();
      step();
      rst = 1'b0;
      #1;

      // reset state
      chk("rst_req", {63'd0, sdram_req}, 64'd0);
      chk("rst_addr", 64'(sdram_addr), 64'd0);
      chk("rst_ok", {60'd0, ok}, 64'd0);
      for (int i = 0; i < 4; i++) chk($sformatf("rst_dout%0d", i), 64'(dout[i]), 64'd0);

      // single miss on slot 2
      step();
      cs[2]   = 1'b1;
      addr[2] = 22'h01234;
      push(2, 22'h01234, 32'hDEADBEEF);
      #1;
      chk("miss_ok2", {63'd0, ok[2]}, 64'd0);
      step();
      #1;
      chk("miss_req_1edge", {63'd0, sdram_req}, 64'd1);
      fetch(1'b0);
      chk("miss_ok2_after", {63'd0, ok[2]}, 64'd1);

      // hit: drop and reapply the same address
      cs[2] = 1'b0;
      step();
      #1;
      chk("hit_ok2_cs_low", {63'd0, ok[2]}, 64'd0);
      cs[2] = 1'b1;
      #1;
      chk("hit_ok2_same_cycle", {63'd0, ok[2]}, 64'd1);
      step();
      #1;
      chk("hit_no_req_a", {63'd0, sdram_req}, 64'd0);
      step();
      #1;
      chk("hit_no_req_b", {63'd0, sdram_req}, 64'd0);
      cs[2] = 1'b0;

      // round robin from reset: order 0,1,2,3,0
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         addr[i] = 22'h100 + 22'(i);
         push(i, 22'h100 + 22'(i), 32'hA0000000 + 32'(i));
      end
      cs = 4'hF;
      #1;
      chk("rr_ok_cleared", {60'd0, ok}, 64'd0);
      fetch(1'b0);
      addr[0] = 22'h200;
      push(0, 22'h200, 32'hA0000200);
      fetch(1'b1);
      // combined ack/rdy: next grant one edge later
      step();
      #1;
      chk("comb_next_req", {63'd0, sdram_req}, 64'd1);
      chk("comb_next_addr", 64'(sdram_addr), 64'h102);
      fetch(1'b0);
      fetch(1'b0);
      fetch(1'b0);
      chk("rr_all_ok", {60'd0, ok}, 64'hF);
      cs = 4'h0;
      step();

      // abort by download during WAIT_RDY
      cs[3]   = 1'b1;
      addr[3] = 22'h3AAAA;
      push(3, 22'h3AAAA, 32'h0BADBAD0);
      wait_grant(e, got);
      sdram_ack = 1'b1;
      step();
      sdram_ack = 1'b0;
      cs[0]   = 1'b1;
      addr[0] = 22'h200;
      #1;
      chk("abort_pre_ok0", {63'd0, ok[0]}, 64'd1);
      downloading = 1'b1;
      step();
      #1;
      chk("abort_req", {63'd0, sdram_req}, 64'd0);
      chk("abort_ok_all", {60'd0, ok}, 64'd0);
      cs[0]     = 1'b0;
      data_rdy  = 1'b1;
      data_read = 32'h0BADBAD0;
      step();
      data_rdy  = 1'b0;
      step();
      #1;
      chk("abort_late_rdy", 64'(dout[3]), 64'hA0000003);
      chk("abort_req_dl", {63'd0, sdram_req}, 64'd0);
      downloading = 1'b0;
      push(3, 22'h3AAAA, 32'h00005EED);
      fetch(1'b0);
      chk("abort_refetch_ok3", {63'd0, ok[3]}, 64'd1);
      cs = 4'h0;
      step();

      // address change mid-fetch
      cs[0]   = 1'b1;
      addr[0] = 22'h10;
      push(0, 22'h10, 32'h00001010);
      wait_grant(e, got);
      sdram_ack = 1'b1;
      step();
      sdram_ack = 1'b0;
      addr[0]   = 22'h20;
      push(0, 22'h20, 32'h00002020);
      step();
      data_rdy  = 1'b1;
      data_read = e.data;
      step();
      data_rdy  = 1'b0;
      #1;
      chk("chg_dout0_old", 64'(dout[0]), 64'h1010);
      chk("chg_ok0", {63'd0, ok[0]}, 64'd0);
      fetch(1'b0);
      chk("chg_ok0_new", {63'd0, ok[0]}, 64'd1);
      cs = 4'h0;
      step();

      // reset mid-fetch, late data_rdy ignored
      cs[1]   = 1'b1;
      addr[1] = 22'h55;
      push(1, 22'h55, 32'h00000077);
      wait_grant(e, got);
      sdram_ack = 1'b1;
      step();
      sdram_ack = 1'b0;
      rst = 1'b1;
      step();
      rst       = 1'b0;
      data_rdy  = 1'b1;
      data_read = 32'h00000077;
      step();
      data_rdy  = 1'b0;
      #1;
      chk("rstmid_dout1", 64'(dout[1]), 64'd0);
      chk("rstmid_dout0", 64'(dout[0]), 64'd0);
      chk("rstmid_ok", {60'd0, ok}, 64'd0);
      chk("rstmid_regrant", {63'd0, sdram_req}, 64'd1);
      push(1, 22'h55, 32'h00006666);
      fetch(1'b0);
      chk("rstmid_ok1", {63'd0, ok[1]}, 64'd1);
      cs = 4'h0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
